// File: rtl/draw_pkg.sv
// Shared definitions for the pixel-drawing engines and the plotter scheduler.
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_GRANT   = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/draw_scheduler_priority_pick.sv
// Lowest-set-bit finder: one-hot of the highest-priority pending request.
module priority_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_onehot,
  output logic         o_none
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_req & (~i_req + N'(1));
  assign o_none   = ~|i_req;

endmodule

// File: rtl/draw_scheduler.sv
// Frame-level arbiter sharing the VGA plotter port between drawing engines.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [NUM_REQ-1:0]       req_enable,
  input  logic [NUM_REQ-1:0]       req_finish,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*C_W-1:0]   req_color,
  output logic [NUM_REQ-1:0]       draw,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_color,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [NUM_REQ-1:0]       timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_none;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_fin;
  logic               w_to;
  pixel_t             w_pix;

  logic [NUM_REQ-1:0] r_draw;
  logic [NUM_REQ-1:0] r_terr;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [C_W-1:0]     r_color;
  logic               r_plot;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;

  priority_pick #(.N(NUM_REQ)) u_pick (
    .i_req    (r_mask),
    .o_onehot (w_pick),
    .o_none   (w_none)
  );

  // Only the granted requester's finish counts; others are masked by the grant.
  assign w_fin = |(req_finish & r_draw);
  assign w_to  = (r_cnt == CNT_LAST);

  always_comb begin
    w_pix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pix.x     = w_pix.x     | (req_x[i*X_W +: X_W]     & {X_W{r_draw[i]}});
      w_pix.y     = w_pix.y     | (req_y[i*Y_W +: Y_W]     & {Y_W{r_draw[i]}});
      w_pix.color = w_pix.color | (req_color[i*C_W +: C_W] & {C_W{r_draw[i]}});
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (frame_tick) w_next = ST_SELECT; else w_next = ST_IDLE;
      ST_SELECT:  if (w_none) w_next = ST_DONE; else w_next = ST_GRANT;
      ST_GRANT:   if (w_fin || w_to) w_next = ST_RELEASE; else w_next = ST_GRANT;
      ST_RELEASE: w_next = ST_SELECT;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_draw    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_terr    <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      r_draw  <= (w_next == ST_GRANT) ? w_pick : '0;
      r_cnt   <= (r_state == ST_GRANT && w_next == ST_GRANT) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == ST_IDLE && frame_tick) begin
        r_mask <= req_enable;
      end else if (r_state == ST_RELEASE) begin
        r_mask <= r_mask & ~w_pick;
      end
      if (frame_tick && r_state != ST_IDLE) begin
        r_overrun <= 1'b1;
      end
      if (r_state == ST_GRANT && !w_fin && w_to) begin
        r_terr <= r_terr | r_draw;
      end
    end
  end

  // The last grant cycle's pixel is not plotted, so vga_plot drops with draw.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_plot  <= 1'b0;
    end else if (r_state == ST_GRANT) begin
      r_x     <= w_pix.x;
      r_y     <= w_pix.y;
      r_color <= w_pix.color;
      r_plot  <= ~(w_fin | w_to);
    end else begin
      r_plot  <= 1'b0;
    end
  end

  assign draw        = r_draw;
  assign vga_x       = r_x;
  assign vga_y       = r_y;
  assign vga_color   = r_color;
  assign vga_plot    = r_plot;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign overrun     = r_overrun;
  assign timeout_err = r_terr;

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-level scheduler that shares the single VGA plotter port between several pixel-drawing engines: the catcher drawer, the falling-square drawer and the score drawer. On each frame tick it grants enabled requesters one at a time in fixed priority order, holds each grant until that engine reports completion or times out, and routes the granted engine's pixel stream to the VGA adapter. It sits between the game FSM, which supplies the frame tick and enable mask, and the VGA adapter.

## Interface
- `NUM_REQ`, 3: number of drawing requesters; index 0 has highest priority.
- `TIMEOUT`, 4096: maximum clock cycles a grant may be held before it is aborted.
- `clock` input 1: system clock, all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `frame_tick` input 1: single-cycle pulse that starts one drawing pass.
- `req_enable` input NUM_REQ: per-requester enable mask, sampled at pass start.
- `req_finish` input NUM_REQ: per-requester `finish_drawing` level.
- `req_x` input NUM_REQ*8: packed x coordinates; requester i occupies [8i+7:8i].
- `req_y` input NUM_REQ*7: packed y coordinates.
- `req_color` input NUM_REQ*3: packed colours.
- `draw` output NUM_REQ: one-hot grant; the granted requester's `draw` input.
- `vga_x` output 8: registered x coordinate to the adapter.
- `vga_y` output 7: registered y coordinate.
- `vga_color` output 3: registered colour.
- `vga_plot` output 1: pixel write enable.
- `busy` output 1: high while a pass is in progress.
- `frame_done` output 1: single-cycle pulse at the end of a pass.
- `overrun` output 1: sticky; set when a `frame_tick` arrives while `busy` is high.
- `timeout_err` output NUM_REQ: sticky per-requester flag, set when that requester's grant is aborted by timeout.

## Operation
- States:
  - `IDLE`: waits for `frame_tick`, then latches `req_enable` into `mask`.
  - `SELECT`: picks the lowest index i with `mask[i]=1`. If none remain, goes to `DONE`.
  - `GRANT`: `draw[i]=1`; each cycle registers `req_x/y/color[i]` to the `vga_*` outputs and drives `vga_plot=1`.
  - `RELEASE`: `draw=0`, `vga_plot=0`; clears `mask[i]`, then returns to `SELECT`.
  - `DONE`: pulses `frame_done`, then returns to `IDLE`.
- Exits from `GRANT`:
  - `req_finish[i]=1`: goes to `RELEASE`.
  - Timeout counter reaches TIMEOUT-1: sets `timeout_err[i]` and goes to `RELEASE`.
- The timeout counter has width clog2(TIMEOUT) and is cleared on every entry to `GRANT`.
- `req_finish` of non-granted requesters is ignored. A requester whose `finish` is already high at grant is released after one `GRANT` cycle.
- `frame_tick` outside `IDLE` is dropped and sets `overrun`. Sticky flags clear only on `reset`.
- Changes to `req_enable` during a pass do not affect that pass.

## Timing
- Reset values: all outputs 0, state `IDLE`, `mask` 0, counter 0.
- Assertion of `reset` forces these values immediately, including mid-pass. `draw` drops without waiting for `finish`.
- Tick sampled at edge T:
  - T+1: `SELECT`, `busy=1`.
  - T+2: `GRANT`, `draw[i]=1`.
  - T+3: first valid `vga_plot` (1-cycle output register).
- `finish` seen at edge F: `draw` low at F+1, `vga_plot` low at F+1.
- A requester granted for G cycles costs G+2 cycles (`GRANT`, `RELEASE`, `SELECT`).
- An all-zero mask gives: `frame_done` high exactly 2 cycles after the tick, no `draw`.
- Each pass ends with `DONE` for one cycle; `busy` falls together with the `frame_done` pulse.
- `draw` is never multi-hot, and is never high in the same cycle as `frame_done`.

## Structure
- Shared `draw_pkg` holds the state encoding (`IDLE`, `SELECT`, `GRANT`, `RELEASE`, `DONE`) and the widths X_W=8, Y_W=7, C_W=3.
- The catcher drawer and this block both import these widths.
- One sub-module, `priority_pick`: combinational lowest-set-bit finder returning a one-hot vector plus a `none` flag.

## Test plan
- Mask 3'b111; requesters finish after 357, 10 and 40 cycles → grants in order 0, 1, 2; `frame_done` at tick+2+(357+2)+(10+2)+(40+2); each `vga_x` sample equals the granted requester's x, one cycle late.
- Mask 3'b000, tick → no `draw`; `frame_done` 2 cycles later; `busy` high for 2 cycles.
- TIMEOUT=16, requester 1 never finishes → `draw[1]` high for 16 cycles, then `timeout_err=3'b010`; requester 2 is still granted afterward.
- Second tick while `busy` → `overrun=1`; pass is unchanged; no second pass starts.
- `reset` asserted mid-`GRANT` on requester 0 → `draw`, `vga_plot` and `busy` are 0 in the same cycle; the next tick starts a fresh pass at requester 0.
- `req_finish[0]` held high at grant → `draw[0]` high for exactly 1 cycle, then requester 1 is granted 2 cycles later.
